// File: rtl/tremolo_pkg.sv
// Shared tremolo definitions: the attenuation index width and the LFO state encoding.
// The shift table downstream uses the same index width.
package tremolo_pkg;

    localparam int unsigned COUNTER_WIDTH = 3;

    typedef logic [COUNTER_WIDTH-1:0] counter_t;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } lfo_state_t;

endpackage

// File: rtl/tremolo_lfo_if.sv
// Control/status bundle between the tremolo controller and the LFO.
// The master drives the controls, and the LFO (slave) returns the index.
interface tremolo_lfo_if #(
    parameter int unsigned RATE_WIDTH = 16
);
    import tremolo_pkg::*;

    logic                  en;
    logic                  sample_valid;
    logic [RATE_WIDTH-1:0] rate;
    counter_t              depth_max;
    counter_t              counter;
    logic                  dir;
    logic                  step;

    modport master (
        output en, sample_valid, rate, depth_max,
        input  counter, dir, step
    );

    modport slave (
        input  en, sample_valid, rate, depth_max,
        output counter, dir, step
    );

endinterface

// File: rtl/sample_prescaler.sv
// Counts sample strobes and flags the strobe that completes one index step.
// A rate of 0 behaves like 1. A prescaler already past a lowered rate wraps on the next strobe.
module sample_prescaler #(
    parameter int unsigned RATE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  sample_valid,
    input  logic [RATE_WIDTH-1:0] rate,
    output logic                  wrap
);

    logic [RATE_WIDTH-1:0] count_q;
    logic [RATE_WIDTH-1:0] last;

    always_comb begin
        last = (rate == '0) ? '0 : rate - RATE_WIDTH'(1);
        wrap = sample_valid && !clear && (count_q >= last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
        end else if (wrap) begin
            count_q <= '0;
        end else if (sample_valid) begin
            count_q <= count_q + RATE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/tremolo_lfo.sv
// Triangle LFO that sweeps the tremolo attenuation index between 0 and depth_max.
// The index moves one step per prescaler wrap.
module tremolo_lfo
    import tremolo_pkg::*;
#(
    parameter int unsigned RATE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    tremolo_lfo_if.slave bus
);

    lfo_state_t            state_q, state_d;
    counter_t              counter_q, counter_d;
    logic                  dir_q, dir_d;
    logic                  step_q, step_d;
    logic                  wrap;
    logic                  clear;
    logic [RATE_WIDTH-1:0] rate;

    assign rate  = bus.rate;
    // The prescaler only runs while sweeping, so it starts from zero on entering UP.
    assign clear = (state_q == IDLE) || !bus.en;

    sample_prescaler #(
        .RATE_WIDTH(RATE_WIDTH)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .sample_valid(bus.sample_valid),
        .rate        (rate),
        .wrap        (wrap)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        step_d    = 1'b0;
        if (!bus.en) begin
            state_d   = IDLE;
            counter_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = UP;
                    counter_d = '0;
                end
                UP: begin
                    if (wrap) begin
                        step_d = 1'b1;
                        if (counter_q < bus.depth_max) begin
                            counter_d = counter_q + counter_t'(1);
                        end else if (counter_q != '0) begin
                            counter_d = counter_q - counter_t'(1);
                            state_d   = DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (wrap) begin
                        step_d = 1'b1;
                        if (counter_q != '0) begin
                            counter_d = counter_q - counter_t'(1);
                        end else begin
                            counter_d = (bus.depth_max != '0) ? counter_t'(1) : '0;
                            state_d   = UP;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    counter_d = '0;
                end
            endcase
        end
        dir_d = (state_d != DOWN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
        end
    end

    assign bus.counter = counter_q;
    assign bus.dir     = dir_q;
    assign bus.step    = step_q;

endmodule

// File: tb/tb_tremolo_lfo.sv
// Scoreboard bench for tremolo_lfo: a triangle-sweep reference model predicts every cycle's outputs.
// A separate monitor compares those predictions against the DUT on the falling edge.
module tb_tremolo_lfo;

    localparam int unsigned RW = 16;

    logic clk = 1'b0;
    logic rst_n;

    tremolo_lfo_if #(.RATE_WIDTH(RW)) bus ();

    tremolo_lfo #(.RATE_WIDTH(RW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] c;
        logic       d;
        logic       s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: sweep level, direction, and strobes counted since the last step.
    bit m_active;
    bit m_up;
    int m_lvl;
    int m_cnt;
    bit m_step;

    function automatic int eff_rate();
        return (bus.rate == 0) ? 1 : int'(bus.rate);
    endfunction

    function automatic void take_step();
        int depth;
        depth = int'(bus.depth_max);
        if (m_up) begin
            if (m_lvl < depth) m_lvl = m_lvl + 1;
            else if (m_lvl > 0) begin
                m_lvl = m_lvl - 1;
                m_up  = 1'b0;
            end
        end else begin
            if (m_lvl > 0) m_lvl = m_lvl - 1;
            else begin
                m_lvl = (depth > 0) ? 1 : 0;
                m_up  = 1'b1;
            end
        end
    endfunction

    function automatic void model_eval();
        m_step = 1'b0;
        if (!rst_n || !bus.en) begin
            m_active = 1'b0;
            m_lvl    = 0;
            m_up     = 1'b1;
            m_cnt    = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_lvl    = 0;
            m_up     = 1'b1;
            m_cnt    = 0;
        end else if (bus.sample_valid) begin
            if (m_cnt + 1 >= eff_rate()) begin
                m_cnt  = 0;
                m_step = 1'b1;
                take_step();
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endfunction

    function automatic bit wraps_now();
        return m_active && rst_n && bus.en && (m_cnt + 1 >= eff_rate());
    endfunction

    task automatic drive(input bit sv);
        bus.sample_valid = sv;
        model_eval();
        q.push_back({3'(m_lvl), m_up, m_step});
        @(posedge clk);
        #1;
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached within cycle budget (got timeout, want reached)", name);
    endtask

    task automatic restart();
        bus.en = 1'b0;
        drive(1'b0);
        bus.en = 1'b1;
    endtask

    // Monitor: one prediction per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.counter !== e.c || bus.dir !== e.d || bus.step !== e.s) begin
                    errors++;
                    $display("FAIL outputs @%0t: got counter=%0d dir=%0b step=%0b, want counter=%0d dir=%0b step=%0b",
                             $time, bus.counter, bus.dir, bus.step, e.c, e.d, e.s);
                end
            end
        end
    end

    initial begin
        bit reached;
        rst_n            = 1'b0;
        bus.en           = 1'b0;
        bus.sample_valid = 1'b0;
        bus.rate         = 16'd4;
        bus.depth_max    = 3'd7;
        repeat (3) drive(1'b0);
        rst_n = 1'b1;

        // Full sweep at ceiling 7, rate 4, strobe every third cycle.
        bus.en = 1'b1;
        for (int i = 0; i < 64 * 3; i++) drive(i % 3 == 0);

        // Fastest sweeps: rate 0 and rate 1 with back-to-back strobes.
        bus.depth_max = 3'd2;
        bus.rate      = 16'd0;
        restart();
        for (int i = 0; i < 20; i++) drive(1'b1);
        bus.rate = 16'd1;
        restart();
        for (int i = 0; i < 20; i++) drive(1'b1);

        // Ceiling 0: index pinned at 0, still stepping.
        bus.depth_max = 3'd0;
        bus.rate      = 16'd2;
        restart();
        for (int i = 0; i < 30; i++) drive($urandom_range(0, 1) == 1);

        // Lower the ceiling below the index while rising at 6.
        bus.depth_max = 3'd7;
        bus.rate      = 16'd2;
        restart();
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_active && m_up && m_lvl == 6) reached = 1'b1;
            else drive(1'b1);
        end
        if (!reached) bound_fail("reach_level6_rising");
        bus.depth_max = 3'd3;
        for (int i = 0; i < 30; i++) drive(1'b1);

        // Drop enable on the wrap that would leave level 5, then re-enable.
        bus.depth_max = 3'd7;
        restart();
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_lvl == 5 && wraps_now()) reached = 1'b1;
            else drive(1'b1);
        end
        if (!reached) bound_fail("reach_wrap_at_level5");
        bus.en = 1'b0;
        drive(1'b1);
        bus.en = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1);

        // Single-cycle reset mid-DOWN with a strobe present.
        bus.rate = 16'd1;
        reached  = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_active && !m_up) reached = 1'b1;
            else drive(1'b1);
        end
        if (!reached) bound_fail("reach_down");
        rst_n = 1'b0;
        drive(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1);

        // Random soak: rate/ceiling changes mid-sweep, sparse enable drops and resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 97 == 0) bus.rate = 16'($urandom_range(0, 5));
            if (i % 61 == 0) bus.depth_max = 3'($urandom_range(0, 7));
            bus.en = ($urandom_range(0, 199) != 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 2) != 0);
        end
        rst_n  = 1'b1;
        bus.en = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
